// File: rtl/map_rom_arbiter_if.sv
// Requester-side bus of the map/turn-point ROM arbiter.
//   req[2:0]     per-requester request (0 render, 1 collide, 2 loader)
//   addr0/1/2    per-requester ROM address, stable while its req is high
//   gnt[2:0]     one-hot grant pulse
//   rdata        shared read-data return bus
//   rvalid[2:0]  one-hot tag saying which requester rdata belongs to
// master: the requesters. slave: the arbiter.
interface map_rom_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 40
);
  logic [2:0]        req;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [2:0]        gnt;
  logic [DATA_W-1:0] rdata;
  logic [2:0]        rvalid;

  modport master (
    output req, addr0, addr1, addr2,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, addr0, addr1, addr2,
    output gnt, rdata, rvalid
  );
endinterface

// File: rtl/map_rom_arbiter.sv
// map_rom_arbiter
// Shares the single-port map/turn-point ROM between the render fetch (0),
// the collision corner lookups (1) and the song loader (2), on the pixel clock.
// The winner gets a one-cycle gnt pulse together with the registered ROM
// address; the read data comes back ROM_LAT+1 cycles later on the shared
// rdata bus, tagged by a one-hot rvalid.
//
// Ports:
//   clk        pixel clock
//   reset_n    asynchronous active-low reset
//   valid      active-video flag
//   load_mode  loader owns the ROM (not playing)
//   bus        requester bus (req, addr0..2, gnt, rdata, rvalid), slave side
//   rom_addr   registered ROM address
//   rom_dout   ROM read data, ROM_LAT cycles after rom_addr
//
// Build option ARB_STATS_EN adds:
//   stat_gnt0/1/2  saturating per-requester grant counters (16 b)
//   stat_max_wait  longest loader wait in cycles (8 b)
// The counters clear on reset and on the rising edge of load_mode. They only
// observe the arbiter; grant decisions are identical with or without them.
//
// state        | meaning
// MODE_BLANK   | blanking: collide > loader, loader forced once starved
// MODE_ACTIVE  | active video: render > collide, loader locked out
// MODE_LOAD    | song preload: loader only
module map_rom_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 40,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid,
  input  logic              load_mode,
  map_rom_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_gnt0,
  output logic [15:0]       stat_gnt1,
  output logic [15:0]       stat_gnt2,
  output logic [7:0]        stat_max_wait
`endif
);

  localparam int STARVE_W = ($clog2(STARVE_MAX + 1) > 4) ? $clog2(STARVE_MAX + 1) : 4;

  typedef enum logic [1:0] {
    MODE_BLANK  = 2'd0,
    MODE_ACTIVE = 2'd1,
    MODE_LOAD   = 2'd2
  } mode_e;

  mode_e               mode_q;
  mode_e               mode_d;
  logic [STARVE_W-1:0] starve_q;
  logic                starve_full;
  logic [2:0]          win_oh;
  logic [ADDR_W-1:0]   win_addr;
  logic [2:0]          tag_q [ROM_LAT];
  logic [2:0]          tag_out;

  // Mode register; the arbitration below uses the registered mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_BLANK;
    end else begin
      mode_q <= mode_d;
    end
  end

  // load_mode outranks valid.
  always_comb begin
    mode_d = MODE_BLANK;
    if (load_mode) begin
      mode_d = MODE_LOAD;
    end else if (valid) begin
      mode_d = MODE_ACTIVE;
    end
  end

  assign starve_full = (starve_q == STARVE_W'(STARVE_MAX));

  // Winner selection on the current requests. Render is never served outside
  // active video, the loader never during it.
  always_comb begin
    win_oh = 3'b000;
    case (mode_q)
      MODE_ACTIVE: begin
        if (bus.req[0]) begin
          win_oh = 3'b001;
        end else if (bus.req[1]) begin
          win_oh = 3'b010;
        end
      end
      MODE_BLANK: begin
        if (bus.req[2] && starve_full) begin
          win_oh = 3'b100;
        end else if (bus.req[1]) begin
          win_oh = 3'b010;
        end else if (bus.req[2]) begin
          win_oh = 3'b100;
        end
      end
      MODE_LOAD: begin
        if (bus.req[2]) begin
          win_oh = 3'b100;
        end
      end
      default: win_oh = 3'b000;
    endcase
  end

  // With no winner the ROM address simply holds.
  always_comb begin
    win_addr = rom_addr;
    if (win_oh[0]) begin
      win_addr = bus.addr0;
    end else if (win_oh[1]) begin
      win_addr = bus.addr1;
    end else if (win_oh[2]) begin
      win_addr = bus.addr2;
    end
  end

  // Loader starvation counter: only blanking cycles where the loader asks and
  // loses count; active/load cycles hold it, a dropped request or a loader
  // grant clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else if (!bus.req[2] || win_oh[2]) begin
      starve_q <= '0;
    end else if (mode_q == MODE_BLANK && !starve_full) begin
      starve_q <= starve_q + STARVE_W'(1);
    end
  end

  // Grant and address leave on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.gnt  <= 3'b000;
      rom_addr <= '0;
    end else begin
      bus.gnt  <= win_oh;
      rom_addr <= win_addr;
    end
  end

  // Tag pipe: tag_q[ROM_LAT-1] lines up with the rom_dout produced by the
  // address issued together with that grant, so in-flight reads keep their
  // owner across mode changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q <= '{default: 3'b000};
    end else begin
      tag_q[0] <= bus.gnt;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[ROM_LAT-1];

  // rdata only moves when a tagged read lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rvalid <= 3'b000;
      bus.rdata  <= '0;
    end else begin
      bus.rvalid <= tag_out;
      if (|tag_out) begin
        bus.rdata <= rom_dout;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic       load_mode_q;
  logic       stat_clr;
  logic [7:0] wait_q;

  assign stat_clr = load_mode & ~load_mode_q;

  // wait_q counts the cycles the loader has been asking without a grant; its
  // value at the moment of the grant is that request's wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_mode_q   <= 1'b0;
      wait_q        <= '0;
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_gnt2     <= '0;
      stat_max_wait <= '0;
    end else begin
      load_mode_q <= load_mode;
      if (stat_clr) begin
        wait_q        <= '0;
        stat_gnt0     <= '0;
        stat_gnt1     <= '0;
        stat_gnt2     <= '0;
        stat_max_wait <= '0;
      end else begin
        if (win_oh[0] && stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 16'd1;
        if (win_oh[1] && stat_gnt1 != 16'hFFFF) stat_gnt1 <= stat_gnt1 + 16'd1;
        if (win_oh[2] && stat_gnt2 != 16'hFFFF) stat_gnt2 <= stat_gnt2 + 16'd1;
        if (win_oh[2] && wait_q > stat_max_wait) stat_max_wait <= wait_q;
        if (!bus.req[2] || win_oh[2]) begin
          wait_q <= '0;
        end else if (wait_q != 8'hFF) begin
          wait_q <= wait_q + 8'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_map_rom_arbiter.sv
module tb_map_rom_arbiter;
  localparam int AW   = 10;
  localparam int DW   = 40;
  localparam int SMAX = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          valid = 1'b0;
  logic          load_mode = 1'b0;
  logic [2:0]    req = 3'b000;
  logic [AW-1:0] a0 = '0, a1 = '0, a2 = '0;

  always #20 clk = ~clk;

  map_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  map_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  assign bus1.req = req;
  assign bus1.addr0 = a0;
  assign bus1.addr1 = a1;
  assign bus1.addr2 = a2;
  assign bus3.req = req;
  assign bus3.addr0 = a0;
  assign bus3.addr1 = a1;
  assign bus3.addr2 = a2;

  logic [AW-1:0] rom_addr1, rom_addr3;
  logic [DW-1:0] rom_dout1, rom_dout3;
  logic [DW-1:0] rom1_q;
  logic [DW-1:0] rom3_q [3];

`ifdef ARB_STATS_EN
  logic [15:0] s1_g0, s1_g1, s1_g2, s3_g0, s3_g1, s3_g2;
  logic [7:0]  s1_mw, s3_mw;
`endif

  map_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .reset_n(reset_n), .valid(valid), .load_mode(load_mode),
    .bus(bus1), .rom_addr(rom_addr1), .rom_dout(rom_dout1)
`ifdef ARB_STATS_EN
    , .stat_gnt0(s1_g0), .stat_gnt1(s1_g1), .stat_gnt2(s1_g2), .stat_max_wait(s1_mw)
`endif
  );

  map_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3), .STARVE_MAX(SMAX)) dut3 (
    .clk(clk), .reset_n(reset_n), .valid(valid), .load_mode(load_mode),
    .bus(bus3), .rom_addr(rom_addr3), .rom_dout(rom_dout3)
`ifdef ARB_STATS_EN
    , .stat_gnt0(s3_g0), .stat_gnt1(s3_g1), .stat_gnt2(s3_g2), .stat_max_wait(s3_mw)
`endif
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    logic [19:0] p;
    p = 20'(a) * 20'd997 + 20'd12345;
    return {a ^ 10'h2A5, a, p};
  endfunction

  // Synchronous ROMs with 1 and 3 cycles of read latency.
  always @(posedge clk) begin
    rom1_q    <= rom_f(rom_addr1);
    rom3_q[0] <= rom_f(rom_addr3);
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign rom_dout1 = rom1_q;
  assign rom_dout3 = rom3_q[2];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: 0 blank, 1 active, 2 load; mode in force for a cycle is
  // the one decided from the previous cycle's inputs.
  int            m_mode;
  int            m_starve;
  logic [AW-1:0] m_rom_addr;
  logic [DW-1:0] m_rdata1, m_rdata3;
  int            hist_w [$];
  logic [AW-1:0] hist_a [$];
  int            last_w;
  int            m_cnt [3];
  int            m_wait, m_maxw;
  logic          m_lm_prev;

  function automatic int pick(input int mode, input logic [2:0] r, input int starve);
    if (mode == 2) return r[2] ? 2 : -1;
    if (mode == 1) return r[0] ? 0 : (r[1] ? 1 : -1);
    if (r[2] && starve == SMAX) return 2;
    if (r[1]) return 1;
    if (r[2]) return 2;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_starve = 0;
    m_rom_addr = '0;
    m_rdata1 = '0;
    m_rdata3 = '0;
    hist_w.delete();
    hist_a.delete();
    for (int i = 0; i < 5; i++) begin
      hist_w.push_back(-1);
      hist_a.push_back('0);
    end
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_wait = 0;
    m_maxw = 0;
    m_lm_prev = 1'b0;
    last_w = -1;
  endtask

  // One clock: predict, advance, compare both DUTs.
  task automatic step();
    int         w;
    logic [2:0] eg, ev1, ev3;
    w = pick(m_mode, req, m_starve);
    if (!req[2] || w == 2) m_starve = 0;
    else if (m_mode == 0 && m_starve < SMAX) m_starve++;
    m_mode = load_mode ? 2 : (valid ? 1 : 0);
    if (w == 0) m_rom_addr = a0;
    else if (w == 1) m_rom_addr = a1;
    else if (w == 2) m_rom_addr = a2;
    hist_w.push_front(w);
    hist_a.push_front(m_rom_addr);
    void'(hist_w.pop_back());
    void'(hist_a.pop_back());
    if (load_mode && !m_lm_prev) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_wait = 0;
      m_maxw = 0;
    end else begin
      if (w >= 0 && m_cnt[w] < 65535) m_cnt[w]++;
      if (!req[2] || w == 2) begin
        if (w == 2 && m_wait > m_maxw) m_maxw = m_wait;
        m_wait = 0;
      end else if (m_wait < 255) begin
        m_wait++;
      end
    end
    m_lm_prev = load_mode;

    @(posedge clk);
    #1;
    eg  = (w < 0) ? 3'b000 : 3'(1 << w);
    ev1 = (hist_w[2] < 0) ? 3'b000 : 3'(1 << hist_w[2]);
    ev3 = (hist_w[4] < 0) ? 3'b000 : 3'(1 << hist_w[4]);
    if (hist_w[2] >= 0) m_rdata1 = rom_f(hist_a[2]);
    if (hist_w[4] >= 0) m_rdata3 = rom_f(hist_a[4]);
    check("gnt_l1", 64'(bus1.gnt), 64'(eg));
    check("gnt_l3", 64'(bus3.gnt), 64'(eg));
    check("rom_addr_l1", 64'(rom_addr1), 64'(m_rom_addr));
    check("rom_addr_l3", 64'(rom_addr3), 64'(m_rom_addr));
    check("rvalid_l1", 64'(bus1.rvalid), 64'(ev1));
    check("rvalid_l3", 64'(bus3.rvalid), 64'(ev3));
    check("rdata_l1", 64'(bus1.rdata), 64'(m_rdata1));
    check("rdata_l3", 64'(bus3.rdata), 64'(m_rdata3));
`ifdef ARB_STATS_EN
    check("stat_gnt0", 64'(s1_g0), 64'(m_cnt[0]));
    check("stat_gnt1", 64'(s1_g1), 64'(m_cnt[1]));
    check("stat_gnt2", 64'(s1_g2), 64'(m_cnt[2]));
    check("stat_max_wait", 64'(s1_mw), 64'(m_maxw));
`endif
    last_w = w;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, 64'({bus1.gnt, bus3.gnt}), 64'd0);
    check({tag, "_rvalid"}, 64'({bus1.rvalid, bus3.rvalid}), 64'd0);
    check({tag, "_rom_addr"}, 64'({rom_addr1, rom_addr3}), 64'd0);
    check({tag, "_rdata"}, 64'(bus1.rdata | bus3.rdata), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero("reset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic set_mode(input logic v, input logic lm);
    valid = v;
    load_mode = lm;
    req = 3'b000;
    step();
    step();
  endtask

  typedef struct {
    logic          v;
    logic          lm;
    logic [2:0]    r;
    logic [AW-1:0] x0, x1, x2;
    logic [2:0]    eg;
    logic [AW-1:0] ea;
  } vec_t;

  vec_t          tbl [11];
  logic [2:0]    rv [16];
  logic [DW-1:0] rd [16];
  int            n;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 3'b011,  5,   9,   3, 3'b001,   5};
    tbl[1]  = '{1'b1, 1'b0, 3'b110, 20,  21,  22, 3'b010,  21};
    tbl[2]  = '{1'b1, 1'b0, 3'b100, 30,  31,  32, 3'b000,  21};
    tbl[3]  = '{1'b0, 1'b0, 3'b001, 40,  41,  42, 3'b000,  21};
    tbl[4]  = '{1'b0, 1'b0, 3'b111, 50,  51,  52, 3'b010,  51};
    tbl[5]  = '{1'b0, 1'b0, 3'b100, 60,  61,  62, 3'b100,  62};
    tbl[6]  = '{1'b1, 1'b1, 3'b011, 70,  71,  72, 3'b000,  62};
    tbl[7]  = '{1'b1, 1'b1, 3'b111, 80,  81,  82, 3'b100,  82};
    tbl[8]  = '{1'b0, 1'b1, 3'b110, 90,  91,  92, 3'b100,  92};
    tbl[9]  = '{1'b1, 1'b0, 3'b010, 100, 101, 102, 3'b010, 101};
    tbl[10] = '{1'b0, 1'b0, 3'b011, 110, 111, 112, 3'b010, 111};

    model_reset();
    do_reset();

    // Single-grant vectors, each from a settled mode with no prior requests.
    for (int i = 0; i < 11; i++) begin
      set_mode(tbl[i].v, tbl[i].lm);
      req = tbl[i].r;
      a0 = tbl[i].x0;
      a1 = tbl[i].x1;
      a2 = tbl[i].x2;
      step();
      check($sformatf("vec%0d_gnt", i), 64'(bus1.gnt), 64'(tbl[i].eg));
      check($sformatf("vec%0d_rom_addr", i), 64'(rom_addr1), 64'(tbl[i].ea));
      req = 3'b000;
    end

    // T1: render beats collide; data returns two cycles after the grant.
    set_mode(1'b1, 1'b0);
    req = 3'b011; a0 = 5; a1 = 9;
    step();
    check("t1_gnt", 64'(bus1.gnt), 64'(3'b001));
    check("t1_rom_addr", 64'(rom_addr1), 64'd5);
    req = 3'b010;
    step();
    check("t1_gnt_collide", 64'(bus1.gnt), 64'(3'b010));
    check("t1_rvalid_early", 64'(bus1.rvalid), 64'(3'b000));
    req = 3'b000;
    step();
    check("t1_rvalid", 64'(bus1.rvalid), 64'(3'b001));
    check("t1_rdata", 64'(bus1.rdata), 64'(rom_f(10'd5)));

    // T2: loader starved by collide in blanking, forced win after SMAX losses.
    set_mode(1'b0, 1'b0);
    req = 3'b110;
    for (int k = 1; k <= 17; k++) begin
      a1 = AW'(k);
      step();
      check($sformatf("t2_gnt_c%0d", k), 64'(bus1.gnt),
            64'((k == 16) ? 3'b100 : 3'b010));
      if (k == 15) check("t2_starve_full", 64'(dut1.starve_q), 64'(SMAX));
      if (k == 16) check("t2_starve_clr", 64'(dut1.starve_q), 64'd0);
    end
    req = 3'b000;

    // T3: load mode outranks valid; loader reads come back in order.
    set_mode(1'b1, 1'b1);
    n = 0;
    for (int k = 0; k < 14; k++) begin
      req = (k < 8) ? 3'b111 : 3'b000;
      a2 = AW'(k);
      step();
      if (k < 8) check($sformatf("t3_gnt_c%0d", k), 64'(bus1.gnt), 64'(3'b100));
      if (bus1.rvalid != 3'b000) begin
        check($sformatf("t3_rvalid_%0d", n), 64'(bus1.rvalid), 64'(3'b100));
        check($sformatf("t3_rdata_%0d", n), 64'(bus1.rdata), 64'(rom_f(AW'(n))));
        n++;
      end
    end
    check("t3_returns", 64'(n), 64'd8);

    // T4: latency-3 ROM, 8 back-to-back render grants, 8 consecutive returns.
    set_mode(1'b1, 1'b0);
    for (int k = 0; k < 13; k++) begin
      req = (k < 8) ? 3'b001 : 3'b000;
      a0 = AW'(200 + k);
      step();
      rv[k] = bus3.rvalid;
      rd[k] = bus3.rdata;
    end
    for (int k = 4; k < 12; k++) begin
      check($sformatf("t4_rvalid_c%0d", k), 64'(rv[k]), 64'(3'b001));
      check($sformatf("t4_rdata_c%0d", k), 64'(rd[k]), 64'(rom_f(AW'(200 + k - 4))));
    end
    check("t4_rvalid_before", 64'(rv[3]), 64'(3'b000));
    check("t4_rvalid_after", 64'(rv[12]), 64'(3'b000));

    // T5: reset one cycle after a grant flushes the read in flight.
    set_mode(1'b1, 1'b0);
    req = 3'b001; a0 = 300;
    step();
    req = 3'b000;
    step();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      check_zero($sformatf("t5_c%0d", k));
    end

`ifdef ARB_STATS_EN
    // T6: 100 render grants, then one loader wait of 7 cycles.
    do_reset();
    set_mode(1'b1, 1'b0);
    req = 3'b001;
    for (int k = 0; k < 100; k++) begin
      a0 = AW'(k);
      step();
    end
    set_mode(1'b0, 1'b0);
    req = 3'b110;
    for (int k = 0; k < 7; k++) step();
    req = 3'b100;
    step();
    req = 3'b000;
    check("t6_stat_gnt0", 64'(s1_g0), 64'd100);
    check("t6_stat_gnt1", 64'(s1_g1), 64'd7);
    check("t6_stat_gnt2", 64'(s1_g2), 64'd1);
    check("t6_stat_max_wait", 64'(s1_mw), 64'd7);
    check("t6_stat_l3", 64'({s3_g0, s3_mw}), 64'({16'd100, 8'd7}));
    load_mode = 1'b1;
    step();
    check("t6_clear_on_load", 64'({s1_g0, s1_g1, s1_g2, s1_mw}), 64'd0);
    check("t6_clear_on_load_l3", 64'({s3_g0, s3_g1, s3_g2, s3_mw}), 64'd0);
`endif

    // Random traffic against the model; requesters hold until granted.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        valid = 1'($urandom);
        load_mode = ($urandom_range(0, 3) == 0);
      end
      for (int i = 0; i < 3; i++) begin
        if (!req[i] || last_w == i) begin
          req[i] = ($urandom_range(0, 3) != 0);
          if (i == 0) a0 = AW'($urandom);
          else if (i == 1) a1 = AW'($urandom);
          else a2 = AW'($urandom);
        end
      end
      step();
      if (c == 1000) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
